// File: rtl/irq_sequencer_pkg.sv
// Shared types and constants for the 6502 interrupt/reset/BRK sequencer.
package irq_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StDummy = 3'd1,
    StPushH = 3'd2,
    StPushL = 3'd3,
    StPushP = 3'd4,
    StVecLo = 3'd5,
    StVecHi = 3'd6
  } seq_state_t;

  typedef enum logic [1:0] {
    SrcRst = 2'd0,
    SrcNmi = 2'd1,
    SrcIrq = 2'd2,
    SrcBrk = 2'd3
  } int_src_t;

  localparam logic [1:0] ADDR_SRC_PC    = 2'd0;
  localparam logic [1:0] ADDR_SRC_STACK = 2'd1;
  localparam logic [1:0] ADDR_SRC_VEC   = 2'd2;

  localparam logic [1:0] PUSH_SRC_PCH = 2'd0;
  localparam logic [1:0] PUSH_SRC_PCL = 2'd1;
  localparam logic [1:0] PUSH_SRC_P   = 2'd2;

  localparam logic [15:0] VEC_NMI_DEFAULT    = 16'hFFFA;
  localparam logic [15:0] VEC_RST_DEFAULT    = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ_DEFAULT    = 16'hFFFE;
  localparam logic [7:0]  STACK_PAGE_DEFAULT = 8'h01;

  // Only IRQ and BRK sequences may be redirected to the NMI vector mid-flight.
  function automatic logic src_hijackable(int_src_t src);
    return (src == SrcIrq) || (src == SrcBrk);
  endfunction

endpackage

// File: rtl/irq_sequencer_nmi_edge_detect.sv
// Two-flop synchronizer on the NMI pin plus a one-cycle falling-edge pulse.
module irq_sequencer_nmi_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic nmi_n_i,
  output logic fall_o
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= nmi_n_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall_o = prev_q & ~sync2_q;

endmodule

// File: rtl/irq_sequencer.sv
// Takes over the datapath for the 7-cycle RESET/NMI/IRQ/BRK sequence and drives bus controls.
module irq_sequencer
  import irq_sequencer_pkg::*;
#(
  parameter logic [15:0] VEC_NMI = VEC_NMI_DEFAULT,
  parameter logic [15:0] VEC_RST = VEC_RST_DEFAULT,
  parameter logic [15:0] VEC_IRQ = VEC_IRQ_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy_i,
  input  logic        nmi_n_i,
  input  logic        irq_n_i,
  input  logic        sync_i,
  input  logic        i_flag_i,
  input  logic        brk_req_i,
  output logic        seq_active_o,
  output logic        force_brk_o,
  output logic        bus_rw_o,
  output logic [1:0]  addr_src_o,
  output logic [15:0] vector_addr_o,
  output logic [1:0]  push_src_o,
  output logic        sp_dec_o,
  output logic        pcl_load_o,
  output logic        pch_load_o,
  output logic        set_i_o,
  output logic        b_flag_o,
  output logic        seq_done_o
);

  seq_state_t  state_q, state_d;
  int_src_t    src_q, src_d;
  logic        nmi_pend_q, nmi_pend_d;
  logic        nmi_fall, advance, nmi_take, irq_take, nmi_clr;
  logic [15:0] vec_base;

  irq_sequencer_nmi_edge_detect u_nmi_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .nmi_n_i (nmi_n_i),
    .fall_o  (nmi_fall)
  );

  // RDY only stalls read cycles.
  assign advance  = rdy_i | ~bus_rw_o;
  assign nmi_take = sync_i & rdy_i & nmi_pend_q;
  assign irq_take = sync_i & rdy_i & ~irq_n_i & ~i_flag_i;
  assign nmi_clr  = (state_q == StVecLo) && (src_q == SrcNmi) && advance;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    nmi_pend_d = nmi_fall | (nmi_pend_q & ~nmi_clr);
    if (state_q == StIdle) begin
      if (nmi_take) begin
        state_d = StDummy;
        src_d   = SrcNmi;
      end else if (irq_take) begin
        state_d = StDummy;
        src_d   = SrcIrq;
      end else if (brk_req_i) begin
        state_d = StDummy;
        src_d   = SrcBrk;
      end
    end else if (advance) begin
      unique case (state_q)
        StDummy: state_d = StPushH;
        StPushH: state_d = StPushL;
        StPushL: state_d = StPushP;
        StPushP: begin
          state_d = StVecLo;
          if (nmi_pend_q && src_hijackable(src_q)) src_d = SrcNmi;
        end
        StVecLo: state_d = StVecHi;
        StVecHi: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StDummy;
      src_q      <= SrcRst;
      nmi_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      nmi_pend_q <= nmi_pend_d;
    end
  end

  always_comb begin
    unique case (src_q)
      SrcRst:  vec_base = VEC_RST;
      SrcNmi:  vec_base = VEC_NMI;
      default: vec_base = VEC_IRQ;
    endcase
  end

  always_comb begin
    seq_active_o  = (state_q != StIdle);
    force_brk_o   = (state_q == StIdle) & (nmi_take | irq_take);
    bus_rw_o      = 1'b1;
    addr_src_o    = ADDR_SRC_PC;
    vector_addr_o = 16'h0000;
    push_src_o    = PUSH_SRC_PCH;
    sp_dec_o      = 1'b0;
    pcl_load_o    = 1'b0;
    pch_load_o    = 1'b0;
    set_i_o       = 1'b0;
    b_flag_o      = (state_q != StIdle) && (src_q == SrcBrk);
    seq_done_o    = 1'b0;
    unique case (state_q)
      StPushH, StPushL, StPushP: begin
        // Reset walks the stack pointer without writing.
        bus_rw_o   = (src_q == SrcRst);
        addr_src_o = ADDR_SRC_STACK;
        sp_dec_o   = 1'b1;
        push_src_o = (state_q == StPushH) ? PUSH_SRC_PCH :
                     (state_q == StPushL) ? PUSH_SRC_PCL : PUSH_SRC_P;
      end
      StVecLo: begin
        addr_src_o    = ADDR_SRC_VEC;
        vector_addr_o = vec_base;
        pcl_load_o    = 1'b1;
        set_i_o       = 1'b1;
      end
      StVecHi: begin
        addr_src_o    = ADDR_SRC_VEC;
        vector_addr_o = vec_base + 16'd1;
        pch_load_o    = 1'b1;
        seq_done_o    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
